// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM states,
// one-hot result encoding and the legal operand width range.
package cmp_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;
  localparam int unsigned RES_W     = 3;

  localparam logic [RES_W-1:0] RES_GT   = 3'b100;
  localparam logic [RES_W-1:0] RES_EQ   = 3'b010;
  localparam logic [RES_W-1:0] RES_LT   = 3'b001;
  localparam logic [RES_W-1:0] RES_NONE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_e;

endpackage

// File: rtl/cmp_bit_cell.sv
// Single-bit magnitude compare cell; exactly one of gt/eq/lt is high.
module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a_bit & ~b_bit;
  assign lt = ~a_bit & b_bit;
  assign eq = ~(a_bit ^ b_bit);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial magnitude comparator: walks operands MSB first through one
// compare cell and returns a registered one-hot greater/equal/less result.
module serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          SIGNED     = 1'b0,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             greater,
  output logic             equal,
  output logic             less,
  output logic             busy
);

  localparam int unsigned      IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_cmp_ctrl: WIDTH must lie in 2..32");
  end

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             fixed_q, fixed_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             cell_gt, cell_eq, cell_lt;
  logic             sign_flip;
  logic [RES_W-1:0] bit_res;

  // Operands shift left each scan cycle, so the cell always sees bit idx at the MSB.
  cmp_bit_cell u_cell (
    .a_bit (a_q[WIDTH-1]),
    .b_bit (b_q[WIDTH-1]),
    .gt    (cell_gt),
    .eq    (cell_eq),
    .lt    (cell_lt)
  );

  // A set sign bit means negative, so the decision swaps at the MSB position.
  assign sign_flip = SIGNED && (idx_q == IDX_MSB);
  assign bit_res   = sign_flip ? {cell_lt, cell_eq, cell_gt} : {cell_gt, cell_eq, cell_lt};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    fixed_d = fixed_q;
    acc_d   = acc_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_MSB;
          fixed_d = 1'b0;
          acc_d   = RES_EQ;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!fixed_q && !cell_eq) begin
          fixed_d = 1'b1;
          acc_d   = bit_res;
        end
        if ((fixed_d && EARLY_EXIT) || (idx_q == '0)) begin
          res_d   = acc_d;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
          a_d   = a_q << 1;
          b_d   = b_q << 1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          res_d   = RES_NONE;
          state_d = ST_IDLE;
        end
      end
      default: begin
        res_d   = RES_NONE;
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      fixed_q     <= 1'b0;
      acc_q       <= RES_NONE;
      res_q       <= RES_NONE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      fixed_q     <= fixed_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign greater   = res_q[2];
  assign equal     = res_q[1];
  assign less      = res_q[0];

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Bench for serial_cmp_ctrl: three configurations (unsigned/early-exit,
// signed/early-exit, unsigned/constant-latency) driven in lockstep.
module tb_serial_cmp_ctrl;
  import cmp_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned NI = 3;
  localparam int unsigned ALL = (1 << NI) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  a, b;
  logic [NI-1:0] in_ready, out_valid, greater, equal, less, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_cmp_ctrl #(.WIDTH(W), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready),
    .greater(greater[0]), .equal(equal[0]), .less(less[0]), .busy(busy[0]));

  serial_cmp_ctrl #(.WIDTH(W), .SIGNED(1'b1), .EARLY_EXIT(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready),
    .greater(greater[1]), .equal(equal[1]), .less(less[1]), .busy(busy[1]));

  serial_cmp_ctrl #(.WIDTH(W), .SIGNED(1'b0), .EARLY_EXIT(1'b0)) u_cst (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a(a), .b(b), .out_valid(out_valid[2]), .out_ready(out_ready),
    .greater(greater[2]), .equal(equal[2]), .less(less[2]), .busy(busy[2]));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   res_u;
    logic [2:0]   res_s;
    int           lat;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] res_of(input int i);
    return {greater[i], equal[i], less[i]};
  endfunction

  function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
    int xv, yv;
    xv = sgn ? int'($signed(x)) : int'({1'b0, x});
    yv = sgn ? int'($signed(y)) : int'({1'b0, y});
    if (xv > yv) return RES_GT;
    if (xv < yv) return RES_LT;
    return RES_EQ;
  endfunction

  // Early-exit latency: cycles until the first differing bit from the MSB is seen.
  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x ^ y;
    for (int i = W - 1; i >= 0; i--) if (d[i]) return W - i;
    return W;
  endfunction

  task automatic run_cmp(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [2:0] eu, input logic [2:0] es, input int lat);
    int         got_lat [NI];
    logic [2:0] got_res [NI];
    logic [2:0] exp_res [NI];
    int         exp_lat [NI];
    exp_res[0] = eu;  exp_res[1] = es;  exp_res[2] = eu;
    exp_lat[0] = lat; exp_lat[1] = lat; exp_lat[2] = W;
    for (int i = 0; i < NI; i++) begin
      got_lat[i] = -1;
      got_res[i] = RES_NONE;
    end
    check("in_ready_before_issue", in_ready, ALL);
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check("busy_after_accept", busy, ALL);
    for (int c = 1; c <= int'(W) + 2; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        if (got_lat[i] < 0 && out_valid[i]) begin
          got_lat[i] = c;
          got_res[i] = res_of(i);
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("latency[%0d] a=%h b=%h", i, xa, xb), got_lat[i], exp_lat[i]);
      check($sformatf("result[%0d] a=%h b=%h", i, xa, xb), got_res[i], exp_res[i]);
    end
  endtask

  initial begin
    logic [2:0]   exp_bp [NI];
    logic [W-1:0] ra, rb;
    logic [W-1:0] one;

    tbl[0] = '{a: 8'hA5, b: 8'h25, res_u: RES_GT, res_s: RES_LT, lat: 1};
    tbl[1] = '{a: 8'h3C, b: 8'h3C, res_u: RES_EQ, res_s: RES_EQ, lat: 8};
    tbl[2] = '{a: 8'hFF, b: 8'h01, res_u: RES_GT, res_s: RES_LT, lat: 1};
    tbl[3] = '{a: 8'h80, b: 8'h00, res_u: RES_GT, res_s: RES_LT, lat: 1};
    tbl[4] = '{a: 8'h12, b: 8'h13, res_u: RES_LT, res_s: RES_LT, lat: 8};
    tbl[5] = '{a: 8'h40, b: 8'h20, res_u: RES_GT, res_s: RES_GT, lat: 2};
    tbl[6] = '{a: 8'h7F, b: 8'h80, res_u: RES_LT, res_s: RES_GT, lat: 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_result", {greater, equal, less}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_release", in_ready, ALL);

    for (int t = 0; t < 7; t++)
      run_cmp(tbl[t].a, tbl[t].b, tbl[t].res_u, tbl[t].res_s, tbl[t].lat);

    // Backpressure: result must hold while the consumer stalls.
    exp_bp[0] = RES_GT; exp_bp[1] = RES_LT; exp_bp[2] = RES_GT;
    out_ready = 1'b0; a = 8'hA5; b = 8'h25; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_out_valid c%0d", c), out_valid, ALL);
      check($sformatf("bp_in_ready c%0d", c), in_ready, 0);
      for (int i = 0; i < NI; i++)
        check($sformatf("bp_result[%0d] c%0d", i, c), res_of(i), exp_bp[i]);
      in_valid = c[0];
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_still_valid", out_valid, ALL);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_released_out_valid", out_valid, 0);
    check("bp_released_in_ready", in_ready, ALL);
    check("bp_released_result", {greater, equal, less}, 0);

    // Reset three cycles into a scan discards the partial comparison.
    a = 8'h3C; b = 8'h3C; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_mid_scan", busy, ALL);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_result", {greater, equal, less}, 0);
    check("rst_mid_in_ready", in_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_in_ready_after", in_ready, ALL);
    check("rst_mid_no_valid", out_valid, 0);
    run_cmp(8'h5A, 8'h5B, RES_LT, RES_LT, 8);

    for (int t = 0; t < 40; t++) begin
      ra = W'($urandom);
      one = W'(1);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (one << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_cmp(ra, rb, ref_res(ra, rb, 1'b0), ref_res(ra, rb, 1'b1), ref_lat(ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
